memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 148 ++++++++++++++
 tb/tb_memory_responder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Single-port word-addressed memory slave with byte-lane writes, programmable
// wait states, address range checking and cycle abort.
module memory_responder #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned WAIT_STATES  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LANES   = 4;
    localparam logic [32:0] SPAN_B  = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RESPOND = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_q,  wait_d;
    logic [31:0]        adr_q,   adr_d;
    logic [31:0]        wdat_q,  wdat_d;
    logic [31:0]        rdat_q,  rdat_d;
    logic [3:0]         sel_q,   sel_d;
    logic               we_q,    we_d;
    logic               ack_q,   ack_d;
    logic               err_q,   err_d;

    logic [31:0]        offset_c;
    logic               in_range_c;
    logic [IDX_W-1:0]   idx_c;
    logic               mem_we_c;

    logic [31:0]        mem [DEPTH_WORDS];

    // Range decode on the latched address; the offset compare is done in 33 bits
    // so a window reaching the top of the address space cannot wrap.
    assign offset_c   = adr_q - BASE_ADDRESS;
    assign in_range_c = (adr_q >= BASE_ADDRESS) && ({1'b0, offset_c} < SPAN_B);
    assign idx_c      = offset_c[IDX_W+1:2];

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Next-state, access decision and response generation
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        rdat_d   = rdat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        mem_we_c = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cyc_i && stb_i) begin
                    adr_d   = adr_i;
                    wdat_d  = dat_i;
                    sel_d   = sel_i;
                    we_d    = we_i;
                    wait_d  = CNT_W'(WAIT_STATES);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!cyc_i) begin
                    state_d = S_IDLE;
                end else if (wait_q != '0) begin
                    wait_d = wait_q - CNT_W'(1);
                end else begin
                    state_d = S_RESPOND;
                    if (in_range_c) begin
                        ack_d = 1'b1;
                        if (we_q) begin
                            mem_we_c = 1'b1;
                        end else begin
                            rdat_d = mem[idx_c];
                        end
                    end else begin
                        err_d  = 1'b1;
                        rdat_d = '0;
                    end
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Storage survives reset; only the committing edge writes, lane by lane
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int n = 0; n < LANES; n++) begin
                if (sel_q[n]) begin
                    mem[idx_c][8*n +: 8] <= wdat_q[8*n +: 8];
                end
            end
        end
    end

    assign dat_o = rdat_q;
    assign ack_o = ack_q;
    assign err_o = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Randomized self-checking bench for memory_responder against an array-based
// reference model of storage, address window and response timing.
module tb_memory_responder;

    localparam int unsigned DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int unsigned WS     = 3;
    localparam int unsigned LAT    = WS + 2;
    localparam int unsigned NWORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        cyc_i, stb_i, we_i;
    logic [31:0] adr_i, dat_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_o;
    logic        ack_o, err_o;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_dat;
    logic        prev_resp = 1'b0;

    always #5 clk = ~clk;

    memory_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDRESS(BASE),
        .WAIT_STATES (WS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cyc_i (cyc_i),
        .stb_i (stb_i),
        .we_i  (we_i),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .sel_i (sel_i),
        .dat_o (dat_o),
        .ack_o (ack_o),
        .err_o (err_o)
    );

    // Responses are single-cycle and mutually exclusive
    always @(negedge clk) begin
        if (!reset) begin
            tests++;
            if ((ack_o && err_o) || (prev_resp && (ack_o || err_o))) begin
                fails++;
                $display("FAIL pulse_rule: ack=%0b err=%0b prev_resp=%0b, expected single exclusive pulse",
                         ack_o, err_o, prev_resp);
            end
        end
        prev_resp = ack_o || err_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit in_rng(input logic [31:0] a);
        return (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'(DEPTH) * 64'd4);
    endfunction

    // Reference: what the storage and dat_o become after one completed access
    task automatic model_apply(input bit we, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic eack, output logic eerr);
        int unsigned idx;
        eack = 1'b0;
        eerr = 1'b0;
        if (!in_rng(a)) begin
            eerr    = 1'b1;
            exp_dat = 32'h0;
        end else begin
            eack = 1'b1;
            idx  = (a - BASE) / 4;
            if (we) begin
                for (int n = 0; n < 4; n++)
                    if (s[n]) mdl[idx][8*n +: 8] = d[8*n +: 8];
            end else begin
                exp_dat = mdl[idx];
            end
        end
    endtask

    // Bus driver: one request, response latency counted from the accept edge
    task automatic xfer(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int unsigned lat,
                        output logic ack, output logic err, output logic [31:0] rd);
        lat = 0; ack = 1'b0; err = 1'b0; rd = 32'h0;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = a; dat_i = d; sel_i = s;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (ack_o || err_o) begin
                lat = n; ack = ack_o; err = err_o; rd = dat_o;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        adr_i = '0; dat_i = '0; sel_i = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (ack_o !== 1'b0 || err_o !== 1'b0 || dat_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: ack=%0b err=%0b dat=%h, expected 0 0 00000000", ack_o, err_o, dat_o);
        end
        reset = 1'b0;
        exp_dat = 32'h0;
    endtask

    task automatic test_init();
        int unsigned lat; logic ack, err, eack, eerr; logic [31:0] rd, a, d;
        for (int w = 0; w <= int'(NWORDS); w++) begin
            a = BASE + 32'((w == int'(NWORDS)) ? (DEPTH - 1) * 4 : w * 4) + 32'($urandom_range(0, 3));
            d = $urandom() | 32'h1;
            xfer(1'b1, a, d, 4'hF, lat, ack, err, rd);
            model_apply(1'b1, a, d, 4'hF, eack, eerr);
            tests++;
            if (lat != LAT || ack !== eack || err !== eerr || rd !== exp_dat) begin
                fails++;
                $display("FAIL init_write a=%h: lat=%0d ack=%0b err=%0b dat=%h, expected lat=%0d ack=%0b err=%0b dat=%h",
                         a, lat, ack, err, rd, LAT, eack, eerr, exp_dat);
            end
        end
    endtask

    task automatic test_byte_lanes();
        int unsigned lat; logic ack, err, eack, eerr; logic [31:0] rd;
        logic [31:0] a = BASE + 32'h10;
        xfer(1'b1, a, 32'h1122_3344, 4'hF, lat, ack, err, rd);
        model_apply(1'b1, a, 32'h1122_3344, 4'hF, eack, eerr);
        xfer(1'b1, a, 32'hAABB_CCDD, 4'b0100, lat, ack, err, rd);
        model_apply(1'b1, a, 32'hAABB_CCDD, 4'b0100, eack, eerr);
        xfer(1'b0, a, 32'h0, 4'hF, lat, ack, err, rd);
        model_apply(1'b0, a, 32'h0, 4'hF, eack, eerr);
        tests++;
        if (lat != LAT || ack !== 1'b1 || err !== 1'b0 || rd !== 32'h11BB_3344) begin
            fails++;
            $display("FAIL byte_lane_read: lat=%0d ack=%0b err=%0b dat=%h, expected lat=%0d 1 0 11bb3344", lat, ack, err, rd, LAT);
        end
        xfer(1'b1, a + 32'd2, 32'hFFFF_FFFF, 4'b0000, lat, ack, err, rd);
        model_apply(1'b1, a + 32'd2, 32'hFFFF_FFFF, 4'b0000, eack, eerr);
        tests++;
        if (lat != LAT || ack !== 1'b1 || err !== 1'b0 || rd !== 32'h11BB_3344) begin
            fails++;
            $display("FAIL sel_zero_write: lat=%0d ack=%0b err=%0b dat=%h, expected lat=%0d 1 0 11bb3344", lat, ack, err, rd, LAT);
        end
        xfer(1'b0, a + 32'd3, 32'h0, 4'h1, lat, ack, err, rd);
        model_apply(1'b0, a + 32'd3, 32'h0, 4'h1, eack, eerr);
        tests++;
        if (lat != LAT || ack !== 1'b1 || rd !== 32'h11BB_3344) begin
            fails++;
            $display("FAIL unaligned_read: lat=%0d ack=%0b dat=%h, expected lat=%0d 1 11bb3344", lat, ack, rd, LAT);
        end
    endtask

    task automatic test_out_of_range();
        int unsigned lat; logic ack, err, eack, eerr; logic [31:0] rd;
        logic [31:0] w0 = mdl[0];
        logic [31:0] wl = mdl[DEPTH-1];
        xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, lat, ack, err, rd);
        model_apply(1'b0, BASE + 32'h4, 32'h0, 4'hF, eack, eerr);
        xfer(1'b0, BASE + 32'(DEPTH * 4), 32'h0, 4'hF, lat, ack, err, rd);
        model_apply(1'b0, BASE + 32'(DEPTH * 4), 32'h0, 4'hF, eack, eerr);
        tests++;
        if (lat != LAT || ack !== 1'b0 || err !== 1'b1 || rd !== 32'h0) begin
            fails++;
            $display("FAIL oor_read_top: lat=%0d ack=%0b err=%0b dat=%h, expected lat=%0d 0 1 00000000", lat, ack, err, rd, LAT);
        end
        xfer(1'b1, BASE - 32'd4, 32'hDEAD_BEEF, 4'hF, lat, ack, err, rd);
        model_apply(1'b1, BASE - 32'd4, 32'hDEAD_BEEF, 4'hF, eack, eerr);
        tests++;
        if (lat != LAT || ack !== 1'b0 || err !== 1'b1) begin
            fails++;
            $display("FAIL oor_write_below: lat=%0d ack=%0b err=%0b, expected lat=%0d 0 1", lat, ack, err, LAT);
        end
        xfer(1'b0, BASE, 32'h0, 4'hF, lat, ack, err, rd);
        model_apply(1'b0, BASE, 32'h0, 4'hF, eack, eerr);
        tests++;
        if (ack !== 1'b1 || rd !== w0) begin
            fails++;
            $display("FAIL oor_storage_word0: ack=%0b dat=%h, expected 1 %h", ack, rd, w0);
        end
        xfer(1'b0, BASE + 32'(DEPTH * 4 - 1), 32'h0, 4'hF, lat, ack, err, rd);
        model_apply(1'b0, BASE + 32'(DEPTH * 4 - 1), 32'h0, 4'hF, eack, eerr);
        tests++;
        if (lat != LAT || ack !== 1'b1 || err !== 1'b0 || rd !== wl) begin
            fails++;
            $display("FAIL last_word_read: lat=%0d ack=%0b err=%0b dat=%h, expected lat=%0d 1 0 %h", lat, ack, err, rd, LAT, wl);
        end
    endtask

    task automatic test_abort();
        int unsigned lat; logic ack, err, eack, eerr; logic [31:0] rd;
        logic [31:0] a = BASE + 32'd32;
        logic [31:0] old = mdl[8];
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = ~old; sel_i = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            tests++;
            if (ack_o !== 1'b0 || err_o !== 1'b0) begin
                fails++;
                $display("FAIL abort_no_response: ack=%0b err=%0b, expected 0 0", ack_o, err_o);
            end
        end
        xfer(1'b0, a, 32'h0, 4'hF, lat, ack, err, rd);
        model_apply(1'b0, a, 32'h0, 4'hF, eack, eerr);
        tests++;
        if (lat != LAT || ack !== 1'b1 || rd !== old) begin
            fails++;
            $display("FAIL abort_old_data: lat=%0d ack=%0b dat=%h, expected lat=%0d 1 %h", lat, ack, rd, LAT, old);
        end
    endtask

    task automatic test_ignore_inputs();
        int unsigned lat = 0; logic ack, err, eack, eerr; logic [31:0] rd;
        logic [31:0] a = BASE + 32'd80;
        logic [31:0] d = $urandom() | 32'h1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d; sel_i = 4'hF;
        @(posedge clk); #1;
        we_i = 1'b0; adr_i = BASE + 32'd120; dat_i = ~d; sel_i = 4'h0;
        for (int n = 2; n <= 20 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (ack_o || err_o) lat = n;
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge clk); #1;
        model_apply(1'b1, a, d, 4'hF, eack, eerr);
        tests++;
        if (lat != LAT) begin
            fails++;
            $display("FAIL ignore_inputs_latency: lat=%0d, expected %0d", lat, LAT);
        end
        xfer(1'b0, a, 32'h0, 4'hF, lat, ack, err, rd);
        model_apply(1'b0, a, 32'h0, 4'hF, eack, eerr);
        tests++;
        if (ack !== 1'b1 || rd !== d) begin
            fails++;
            $display("FAIL ignore_inputs_data: ack=%0b dat=%h, expected 1 %h", ack, rd, d);
        end
    endtask

    task automatic test_reset_mid_busy();
        int unsigned lat; logic ack, err, eack, eerr; logic [31:0] rd;
        logic [31:0] a9 = BASE + 32'd36;
        logic [31:0] a10 = BASE + 32'd40;
        logic [31:0] old9 = mdl[9];
        logic [31:0] new10 = $urandom() | 32'h1;
        bit seen = 1'b0;
        xfer(1'b0, a9, 32'h0, 4'hF, lat, ack, err, rd);
        model_apply(1'b0, a9, 32'h0, 4'hF, eack, eerr);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = a9; dat_i = ~old9; sel_i = 4'hF;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if (ack_o !== 1'b0 || err_o !== 1'b0 || dat_o !== 32'h0) begin
            fails++;
            $display("FAIL async_reset_busy: ack=%0b err=%0b dat=%h, expected 0 0 00000000", ack_o, err_o, dat_o);
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_dat = 32'h0;
        xfer(1'b0, a9, 32'h0, 4'hF, lat, ack, err, rd);
        model_apply(1'b0, a9, 32'h0, 4'hF, eack, eerr);
        tests++;
        if (lat != LAT || ack !== 1'b1 || rd !== old9) begin
            fails++;
            $display("FAIL reset_cancels_write: lat=%0d ack=%0b dat=%h, expected lat=%0d 1 %h", lat, ack, rd, LAT, old9);
        end
        // Reset landing in the response cycle must not undo the committed write
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = a10; dat_i = new10; sel_i = 4'hF;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(posedge clk); #1;
            if (ack_o) seen = 1'b1;
        end
        reset = 1'b1;
        #1;
        tests++;
        if (!seen || ack_o !== 1'b0 || dat_o !== 32'h0) begin
            fails++;
            $display("FAIL async_reset_respond: seen=%0b ack=%0b dat=%h, expected 1 0 00000000", seen, ack_o, dat_o);
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_dat = 32'h0;
        model_apply(1'b1, a10, new10, 4'hF, eack, eerr);
        xfer(1'b0, a10, 32'h0, 4'hF, lat, ack, err, rd);
        model_apply(1'b0, a10, 32'h0, 4'hF, eack, eerr);
        tests++;
        if (lat != LAT || ack !== 1'b1 || rd !== new10) begin
            fails++;
            $display("FAIL committed_write_persists: lat=%0d ack=%0b dat=%h, expected lat=%0d 1 %h", lat, ack, rd, LAT, new10);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned n1 = 0, n2 = 0;
        logic [31:0] rd1 = 32'h0, rd2 = 32'h0;
        logic [31:0] e1 = mdl[11];
        logic [31:0] e2 = mdl[12];
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = BASE + 32'd44; dat_i = '0; sel_i = 4'hF;
        for (int n = 1; n <= 20 && n1 == 0; n++) begin
            @(posedge clk); #1;
            if (ack_o) begin n1 = n; rd1 = dat_o; end
        end
        adr_i = BASE + 32'd48;
        for (int n = 1; n <= 20 && n2 == 0; n++) begin
            @(posedge clk); #1;
            if (ack_o) begin n2 = n; rd2 = dat_o; end
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge clk); #1;
        exp_dat = e2;
        tests++;
        if (n1 != LAT || rd1 !== e1) begin
            fails++;
            $display("FAIL b2b_first: lat=%0d dat=%h, expected lat=%0d %h", n1, rd1, LAT, e1);
        end
        tests++;
        if (n2 != WS + 3 || rd2 !== e2) begin
            fails++;
            $display("FAIL b2b_second: gap=%0d dat=%h, expected gap=%0d %h", n2, rd2, WS + 3, e2);
        end
    endtask

    task automatic test_random();
        int unsigned lat; logic ack, err, eack, eerr; logic [31:0] rd, a, d;
        logic [3:0] s; bit we;
        logic [31:0] bad [6];
        bad[0] = BASE - 32'd4;
        bad[1] = BASE - 32'd1;
        bad[2] = BASE + 32'(DEPTH * 4);
        bad[3] = BASE + 32'(DEPTH * 4 + 7);
        bad[4] = 32'hFFFF_FFFC;
        bad[5] = 32'h0;
        for (int t = 0; t < 80; t++) begin
            we = 1'($urandom_range(0, 1));
            d  = $urandom();
            s  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 15)
                a = bad[$urandom_range(0, 5)];
            else
                a = BASE + 32'($urandom_range(0, NWORDS - 1) * 4) + 32'($urandom_range(0, 3));
            xfer(we, a, d, s, lat, ack, err, rd);
            model_apply(we, a, d, s, eack, eerr);
            tests++;
            if (lat != LAT || ack !== eack || err !== eerr || rd !== exp_dat) begin
                fails++;
                $display("FAIL random_%0d we=%0b a=%h sel=%h: lat=%0d ack=%0b err=%0b dat=%h, expected lat=%0d ack=%0b err=%0b dat=%h",
                         t, we, a, s, lat, ack, err, rd, LAT, eack, eerr, exp_dat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_byte_lanes();
        test_out_of_range();
        test_abort();
        test_ignore_inputs();
        test_reset_mid_busy();
        test_back_to_back();
        test_random();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
